// File: rtl/kb_autotype_pkg.sv
// Shared types, matrix constants and key_code field helpers for the keystroke injector.
package kb_autotype_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_PRE,
        PRESS,
        RELEASE,
        PAUSE
    } state_t;

    localparam logic [3:0] SHIFT_ROW = 4'd2;
    localparam logic [2:0] SHIFT_COL = 3'd5;
    localparam logic [3:0] PAUSE_ROW = 4'd15;
    localparam logic [3:0] NUM_ROWS  = 4'd10;

    function automatic logic code_shift(input logic [7:0] code);
        return code[7];
    endfunction

    function automatic logic [3:0] code_row(input logic [7:0] code);
        return code[6:3];
    endfunction

    function automatic logic [2:0] code_col(input logic [7:0] code);
        return code[2:0];
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/kb_code_fifo.sv
// Synchronous FIFO, first-word fall-through; push/pop take effect on the next clock edge.
// Pushes while full and pops while empty are ignored; flush empties it and overrides both.
module kb_code_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full & ~flush;
    assign do_pop   = pop & ~empty & ~flush;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/kb_autotype.sv
// Replays queued CPC matrix key codes as timed presses on an active-low column vector.
// A popped key is pressed from the next cycle; key_ready drops when the queue is full.
module kb_autotype
    import kb_autotype_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int HOLD_CYCLES   = 1000000,
    parameter int GAP_CYCLES    = 1000000,
    parameter int SETTLE_CYCLES = 250000,
    parameter int PAUSE_CYCLES  = 16000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output logic       key_ready,
    input  logic       abort,
    input  logic [3:0] rowselect,
    output logic [7:0] inj_columns,
    output logic       busy,
    output logic       bad_code
);
    localparam int MAX_CYC = max2(max2(HOLD_CYCLES, GAP_CYCLES), max2(SETTLE_CYCLES, PAUSE_CYCLES));
    localparam int CW      = $clog2(MAX_CYC) + 1;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [3:0]          cur_row, cur_row_nxt;
    logic [2:0]          cur_col, cur_col_nxt;
    logic                cur_shift, cur_shift_nxt;
    logic                key_on, key_on_nxt;
    logic                shift_on, shift_on_nxt;
    logic                bad_nxt;

    logic [7:0]          fifo_dat;
    logic                fifo_full;
    logic                fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                push;
    logic                pop;

    assign key_ready = ~fifo_full;
    assign push      = key_valid & key_ready;
    assign pop       = (state == IDLE) & ~fifo_empty & ~abort;
    assign busy      = (fifo_count != '0) | (state != IDLE);

    kb_code_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (key_code),
        .pop       (pop),
        .flush     (abort),
        .pop_data  (fifo_dat),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_row   <= '0;
            cur_col   <= '0;
            cur_shift <= 1'b0;
            key_on    <= 1'b0;
            shift_on  <= 1'b0;
            bad_code  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cur_row   <= cur_row_nxt;
            cur_col   <= cur_col_nxt;
            cur_shift <= cur_shift_nxt;
            key_on    <= key_on_nxt;
            shift_on  <= shift_on_nxt;
            bad_code  <= bad_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        cur_row_nxt   = cur_row;
        cur_col_nxt   = cur_col;
        cur_shift_nxt = cur_shift;
        key_on_nxt    = key_on;
        shift_on_nxt  = shift_on;
        bad_nxt       = 1'b0;

        if (abort) begin
            state_nxt    = IDLE;
            cnt_nxt      = '0;
            key_on_nxt   = 1'b0;
            shift_on_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (code_row(fifo_dat) == PAUSE_ROW) begin
                            state_nxt = PAUSE;
                            cnt_nxt   = CW'(PAUSE_CYCLES - 1);
                        end else if (code_row(fifo_dat) >= NUM_ROWS) begin
                            bad_nxt = 1'b1;
                        end else begin
                            cur_row_nxt   = code_row(fifo_dat);
                            cur_col_nxt   = code_col(fifo_dat);
                            cur_shift_nxt = code_shift(fifo_dat);
                            if (code_shift(fifo_dat)) begin
                                state_nxt    = SHIFT_PRE;
                                shift_on_nxt = 1'b1;
                                cnt_nxt      = CW'(SETTLE_CYCLES - 1);
                            end else begin
                                state_nxt  = PRESS;
                                key_on_nxt = 1'b1;
                                cnt_nxt    = CW'(HOLD_CYCLES - 1);
                            end
                        end
                    end
                end
                SHIFT_PRE: begin
                    if (cnt == '0) begin
                        state_nxt  = PRESS;
                        key_on_nxt = 1'b1;
                        cnt_nxt    = CW'(HOLD_CYCLES - 1);
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
                PRESS: begin
                    if (cnt == '0) begin
                        state_nxt    = RELEASE;
                        key_on_nxt   = 1'b0;
                        shift_on_nxt = 1'b0;
                        cnt_nxt      = CW'(GAP_CYCLES - 1);
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
                RELEASE, PAUSE: begin
                    if (cnt == '0) state_nxt = IDLE;
                    else           cnt_nxt   = cnt - CW'(1);
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Rows 10-15 do not exist on the matrix, so nothing is ever driven there.
    always_comb begin
        inj_columns = 8'hFF;
        if (rowselect < NUM_ROWS) begin
            if (key_on && rowselect == cur_row)     inj_columns[cur_col]   = 1'b0;
            if (shift_on && rowselect == SHIFT_ROW) inj_columns[SHIFT_COL] = 1'b0;
        end
    end

endmodule
